// File: rtl/ca_cycle_detector.sv
// Cycle detector for a cellular-automaton simulator: keeps a short history of
// generations and reports the first repeat (period and transient) or a budget miss.
module ca_cycle_detector #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8,
    parameter int MAX_GEN = 255
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     START,
    input  logic [WIDTH-1:0]         GEN,
    input  logic                     GEN_VALID,
    output logic                     DONE,
    output logic                     FOUND,
    output logic [4:0]               PERIOD,
    output logic [7:0]               TRANSIENT,
    output logic [7:0]               GEN_COUNT,
    input  logic [$clog2(DEPTH)-1:0] RD_IDX,
    output logic [WIDTH-1:0]         RD_DATA
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [7:0] MAX_C = 8'(MAX_GEN);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HIT  = 2'd2;
    localparam logic [1:0] ST_MISS = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [WIDTH-1:0] hist_q [DEPTH];
    logic [WIDTH-1:0] hist_d [DEPTH];
    logic [7:0]       gen_count_q, gen_count_d;
    logic             done_q, done_d;
    logic             found_q, found_d;
    logic [4:0]       period_q, period_d;
    logic [7:0]       transient_q, transient_d;

    logic             hit;
    logic [IDX_W-1:0] match_idx;
    logic [4:0]       match_age;

    // Generation counter never wraps; it parks at the budget.
    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c >= MAX_C) ? c : c + 8'd1;
    endfunction

    // Scan oldest to newest so the youngest matching entry (smallest age) wins.
    always_comb begin
        hit       = 1'b0;
        match_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (vld_q[i] && (hist_q[i] == GEN)) begin
                hit       = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
        match_age = 5'(match_idx) + 5'd1;
    end

    always_comb begin
        state_d     = state_q;
        vld_d       = vld_q;
        hist_d      = hist_q;
        gen_count_d = gen_count_q;
        done_d      = done_q;
        found_d     = found_q;
        period_d    = period_q;
        transient_d = transient_q;

        if (START) begin
            state_d     = ST_RUN;
            vld_d       = '0;
            gen_count_d = 8'd0;
            done_d      = 1'b0;
            found_d     = 1'b0;
            period_d    = 5'd0;
            transient_d = 8'd0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (GEN_VALID) begin
                        hist_d[0] = GEN;
                        for (int i = 1; i < DEPTH; i++) begin
                            hist_d[i] = hist_q[i-1];
                        end
                        vld_d       = {vld_q[DEPTH-2:0], 1'b1};
                        gen_count_d = sat_inc(gen_count_q);
                        if (hit) begin
                            state_d     = ST_HIT;
                            done_d      = 1'b1;
                            found_d     = 1'b1;
                            period_d    = match_age;
                            transient_d = gen_count_q - 8'(match_age);
                        end else if (gen_count_d == MAX_C) begin
                            state_d = ST_MISS;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            vld_q       <= '0;
            gen_count_q <= 8'd0;
            done_q      <= 1'b0;
            found_q     <= 1'b0;
            period_q    <= 5'd0;
            transient_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            vld_q       <= vld_d;
            gen_count_q <= gen_count_d;
            done_q      <= done_d;
            found_q     <= found_d;
            period_q    <= period_d;
            transient_q <= transient_d;
        end
    end

    // History payload is masked by the valid flags, so it needs no reset.
    always_ff @(posedge CLK) begin
        hist_q <= hist_d;
    end

    assign DONE      = done_q;
    assign FOUND     = found_q;
    assign PERIOD    = period_q;
    assign TRANSIENT = transient_q;
    assign GEN_COUNT = gen_count_q;
    assign RD_DATA   = vld_q[RD_IDX] ? hist_q[RD_IDX] : '0;

endmodule

// File: tb/tb_ca_cycle_detector.sv
// Directed-vector bench for ca_cycle_detector (WIDTH=8, DEPTH=8, MAX_GEN=20).
module tb_ca_cycle_detector;

    logic       CLK = 1'b0;
    logic       RST;
    logic       START;
    logic [7:0] GEN;
    logic       GEN_VALID;
    logic       DONE;
    logic       FOUND;
    logic [4:0] PERIOD;
    logic [7:0] TRANSIENT;
    logic [7:0] GEN_COUNT;
    logic [2:0] RD_IDX;
    logic [7:0] RD_DATA;

    int n_vec = 0;
    int n_err = 0;

    ca_cycle_detector #(.WIDTH(8), .DEPTH(8), .MAX_GEN(20)) dut (
        .CLK(CLK), .RST(RST), .START(START), .GEN(GEN), .GEN_VALID(GEN_VALID),
        .DONE(DONE), .FOUND(FOUND), .PERIOD(PERIOD), .TRANSIENT(TRANSIENT),
        .GEN_COUNT(GEN_COUNT), .RD_IDX(RD_IDX), .RD_DATA(RD_DATA)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_start();
        @(negedge CLK);
        START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
    endtask

    task automatic accept(input logic [7:0] v);
        @(negedge CLK);
        GEN = v;
        GEN_VALID = 1'b1;
        @(posedge CLK);
        #1 GEN_VALID = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge CLK);
        GEN = 8'h55;
        GEN_VALID = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_rd(input string tag, input logic [2:0] idx, input logic [7:0] exp);
        RD_IDX = idx;
        #1 chk(tag, 32'(RD_DATA), 32'(exp));
    endtask

    task automatic chk_result(input string tag, input logic d, input logic f,
                              input logic [4:0] p, input logic [7:0] t, input logic [7:0] c);
        chk({tag, ".done"},      32'(DONE),      32'(d));
        chk({tag, ".found"},     32'(FOUND),     32'(f));
        chk({tag, ".period"},    32'(PERIOD),    32'(p));
        chk({tag, ".transient"}, 32'(TRANSIENT), 32'(t));
        chk({tag, ".count"},     32'(GEN_COUNT), 32'(c));
    endtask

    initial begin
        logic [7:0] p2 [4];
        p2[0] = 8'h10; p2[1] = 8'h38; p2[2] = 8'h6C; p2[3] = 8'h38;

        RST = 1'b1; START = 1'b0; GEN = 8'h00; GEN_VALID = 1'b0; RD_IDX = 3'd0;
        #12;
        chk_result("reset", 1'b0, 1'b0, 5'd0, 8'd0, 8'd0);
        chk_rd("reset.rd0", 3'd0, 8'h00);
        @(negedge CLK);
        RST = 1'b0;

        // IDLE ignores GEN_VALID
        accept(8'hAA);
        chk("idle.count", 32'(GEN_COUNT), 32'd0);
        chk_rd("idle.rd0", 3'd0, 8'h00);

        // Fixed point
        do_start();
        accept(8'h00);
        chk_result("fix1", 1'b0, 1'b0, 5'd0, 8'd0, 8'd1);
        accept(8'h00);
        chk_result("fix2", 1'b1, 1'b1, 5'd1, 8'd0, 8'd2);

        // Period 2; START from HIT clears everything
        do_start();
        chk_result("p2.start", 1'b0, 1'b0, 5'd0, 8'd0, 8'd0);
        chk_rd("p2.start.rd0", 3'd0, 8'h00);
        for (int i = 0; i < 3; i++) accept(p2[i]);
        chk("p2.pre.done", 32'(DONE), 32'd0);
        accept(p2[3]);
        chk_result("p2", 1'b1, 1'b1, 5'd2, 8'd1, 8'd4);
        chk_rd("p2.rd0", 3'd0, 8'h38);
        chk_rd("p2.rd1", 3'd1, 8'h6C);
        chk_rd("p2.rd2", 3'd2, 8'h38);
        chk_rd("p2.rd3", 3'd3, 8'h10);
        chk_rd("p2.rd4", 3'd4, 8'h00);
        accept(8'h6C);
        chk_result("p2.frozen", 1'b1, 1'b1, 5'd2, 8'd1, 8'd4);
        chk_rd("p2.frozen.rd0", 3'd0, 8'h38);

        // Same stream with GEN_VALID gaps
        do_start();
        for (int i = 0; i < 4; i++) begin
            accept(p2[i]);
            idle_cycle();
        end
        chk_result("gap", 1'b1, 1'b1, 5'd2, 8'd1, 8'd4);

        // Period 9 exceeds DEPTH: budget miss at 20 accepts
        do_start();
        for (int i = 0; i < 19; i++) accept(8'((i % 9) + 1));
        chk_result("miss.19", 1'b0, 1'b0, 5'd0, 8'd0, 8'd19);
        accept(8'h02);
        chk_result("miss.20", 1'b1, 1'b0, 5'd0, 8'd0, 8'd20);
        accept(8'h02);
        chk_result("miss.frozen", 1'b1, 1'b0, 5'd0, 8'd0, 8'd20);
        chk_rd("miss.rd0", 3'd0, 8'h02);
        chk_rd("miss.rd7", 3'd7, 8'h04);

        // Asynchronous reset mid-run
        do_start();
        accept(8'hA1); accept(8'hA2); accept(8'hA3);
        chk("arst.pre.count", 32'(GEN_COUNT), 32'd3);
        @(posedge CLK);
        #3 RST = 1'b1;
        #1;
        chk_result("arst", 1'b0, 1'b0, 5'd0, 8'd0, 8'd0);
        chk_rd("arst.rd0", 3'd0, 8'h00);
        #2 RST = 1'b0;
        accept(8'hA4);
        chk("arst.nostart.count", 32'(GEN_COUNT), 32'd0);
        chk_rd("arst.nostart.rd0", 3'd0, 8'h00);

        // START coincident with GEN_VALID
        do_start();
        for (int i = 0; i < 5; i++) accept(8'(8'h11 + i));
        chk("coin.pre.count", 32'(GEN_COUNT), 32'd5);
        @(negedge CLK);
        START = 1'b1; GEN = 8'h77; GEN_VALID = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0; GEN_VALID = 1'b0;
        chk_result("coin", 1'b0, 1'b0, 5'd0, 8'd0, 8'd0);
        chk_rd("coin.rd0", 3'd0, 8'h00);
        chk_rd("coin.rd1", 3'd1, 8'h00);
        accept(8'h77);
        chk_result("coin.after", 1'b0, 1'b0, 5'd0, 8'd0, 8'd1);
        chk_rd("coin.after.rd0", 3'd0, 8'h77);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
